// File: rtl/trace_commit_sequencer.sv
// Buffers up to LANES retire records per cycle in program order and replays them to a
// single-record tracer as isolated one-cycle valid pulses separated by GAP_CYCLES idle cycles.
module trace_commit_sequencer #(
    parameter int LANES      = 3,
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [LANES-1:0]    commit_valid_i,
    input  logic [32*LANES-1:0] commit_pc_i,
    input  logic [32*LANES-1:0] commit_instr_i,
    input  logic [32*LANES-1:0] commit_rd_data_i,
    input  logic [32*LANES-1:0] commit_mem_addr_i,
    input  logic [32*LANES-1:0] commit_mem_data_i,
    input  logic [32*LANES-1:0] commit_fflags_i,
    input  logic [5*LANES-1:0]  commit_rd_addr_i,
    input  logic [LANES-1:0]    commit_is_load_i,
    input  logic [LANES-1:0]    commit_is_store_i,
    input  logic [LANES-1:0]    commit_is_float_i,
    input  logic [2*LANES-1:0]  commit_mem_size_i,
    output logic                commit_ready_o,
    output logic                trace_valid_o,
    output logic [31:0]         trace_pc_o,
    output logic [31:0]         trace_instr_o,
    output logic [31:0]         trace_rd_data_o,
    output logic [31:0]         trace_mem_addr_o,
    output logic [31:0]         trace_mem_data_o,
    output logic [31:0]         trace_fflags_o,
    output logic [4:0]          trace_rd_addr_o,
    output logic                trace_is_load_o,
    output logic                trace_is_store_o,
    output logic                trace_is_float_o,
    output logic [1:0]          trace_mem_size_o,
    output logic                overflow_o,
    output logic                empty_o,
    output logic [31:0]         record_count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rd_data;
        logic [31:0] mem_addr;
        logic [31:0] mem_data;
        logic [31:0] fflags;
        logic [4:0]  rd_addr;
        logic        is_load;
        logic        is_store;
        logic        is_float;
        logic [1:0]  mem_size;
    } rec_t;

    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

    rec_t          mem [DEPTH];
    rec_t          lane_rec [LANES];
    logic [CW-1:0] prefix [LANES+1];

    state_t        state_reg, state_next;
    logic [GW-1:0] gap_reg, gap_next;
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] push_num;
    logic          ready;
    logic          pop;
    rec_t          out_reg;
    logic          valid_reg;
    logic          overflow_reg;
    logic [31:0]   rec_cnt_reg;

    // prefix[k] = number of valid lanes below lane k, i.e. lane k's slot offset
    assign prefix[0] = '0;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_rec[gi] = '{
                pc:       commit_pc_i[32*gi +: 32],
                instr:    commit_instr_i[32*gi +: 32],
                rd_data:  commit_rd_data_i[32*gi +: 32],
                mem_addr: commit_mem_addr_i[32*gi +: 32],
                mem_data: commit_mem_data_i[32*gi +: 32],
                fflags:   commit_fflags_i[32*gi +: 32],
                rd_addr:  commit_rd_addr_i[5*gi +: 5],
                is_load:  commit_is_load_i[gi],
                is_store: commit_is_store_i[gi],
                is_float: commit_is_float_i[gi],
                mem_size: commit_mem_size_i[2*gi +: 2]
            };
            assign prefix[gi+1] = prefix[gi] + CW'(commit_valid_i[gi]);
        end
    endgenerate

    // Credit is based on the registered occupancy only; a pop in the same cycle is not counted.
    assign ready    = (32'(DEPTH) - 32'(count_reg)) >= 32'(LANES);
    assign push_num = ready ? prefix[LANES] : '0;

    always_comb begin
        state_next = state_reg;
        gap_next   = gap_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (count_reg != '0) begin
                    pop        = 1'b1;
                    state_next = PULSE;
                end
            end
            PULSE: begin
                gap_next   = '0;
                state_next = GAP;
            end
            GAP: begin
                if (gap_reg == GW'(GAP_CYCLES - 1)) begin
                    if (count_reg != '0) begin
                        pop        = 1'b1;
                        state_next = PULSE;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    gap_next = gap_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < LANES; k++) begin
            if (ready && commit_valid_i[k]) begin
                mem[wr_ptr_reg + PW'(prefix[k])] <= lane_rec[k];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            gap_reg      <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            out_reg      <= '0;
            valid_reg    <= 1'b0;
            overflow_reg <= 1'b0;
            rec_cnt_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            gap_reg    <= gap_next;
            wr_ptr_reg <= wr_ptr_reg + PW'(push_num);
            rd_ptr_reg <= rd_ptr_reg + PW'(pop);
            count_reg  <= count_reg + push_num - CW'(pop);
            valid_reg  <= pop;
            if (pop) begin
                out_reg <= mem[rd_ptr_reg];
            end
            if (state_reg == PULSE) begin
                rec_cnt_reg <= rec_cnt_reg + 32'd1;
            end
            if (!ready && (commit_valid_i != '0)) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign commit_ready_o   = ready;
    assign trace_valid_o    = valid_reg;
    assign trace_pc_o       = out_reg.pc;
    assign trace_instr_o    = out_reg.instr;
    assign trace_rd_data_o  = out_reg.rd_data;
    assign trace_mem_addr_o = out_reg.mem_addr;
    assign trace_mem_data_o = out_reg.mem_data;
    assign trace_fflags_o   = out_reg.fflags;
    assign trace_rd_addr_o  = out_reg.rd_addr;
    assign trace_is_load_o  = out_reg.is_load;
    assign trace_is_store_o = out_reg.is_store;
    assign trace_is_float_o = out_reg.is_float;
    assign trace_mem_size_o = out_reg.mem_size;
    assign overflow_o       = overflow_reg;
    assign empty_o          = (count_reg == '0) && (state_reg == IDLE);
    assign record_count_o   = rec_cnt_reg;

endmodule
